// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// fetch_pkg : shared types, widths and offset helper for the fetch stage
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int ADDR_W   = 64;
  localparam int B_OFF_W  = 26;
  localparam int CB_OFF_W = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Sign-extend a branch offset (B when is_b, otherwise CB in the low bits)
  // and scale it from words to bytes.
  function automatic logic [ADDR_W-1:0] sext_shl2(input logic [B_OFF_W-1:0] off,
                                                  input logic is_b);
    if (is_b)
      return {{(ADDR_W-B_OFF_W-2){off[B_OFF_W-1]}}, off, 2'b00};
    else
      return {{(ADDR_W-CB_OFF_W-2){off[CB_OFF_W-1]}}, off[CB_OFF_W-1:0], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
//------------------------------------------------------------------------------
// next_pc_calc : combinational sequential/branch target selection
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               BrTaken,
  input  logic               UncondBr,
  output logic [ADDR_W-1:0]  next_pc
);

  logic [B_OFF_W-1:0] w_off_field;
  logic [ADDR_W-1:0]  w_offset;
  logic               w_unused_opcode;

  // CB offset lives at [23:5]; realign it to bit 0 so one helper serves both
  assign w_off_field     = UncondBr ? instruction[B_OFF_W-1:0]
                                    : {{(B_OFF_W-CB_OFF_W){1'b0}}, instruction[23:5]};
  assign w_offset        = sext_shl2(w_off_field, UncondBr);
  assign w_unused_opcode = ^instruction[INSTR_W-1:B_OFF_W];

  always_comb begin
    next_pc = pc + 64'd4;
    if (BrTaken)
      next_pc = pc + w_offset;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// instr_fetch : PC owner and instruction memory request/hold stage
// Optional    : FETCH_PERF_CNT_EN adds fetch_count / stall_count
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               BrTaken,
  input  logic               UncondBr,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc,
  output logic               instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instruction;
  logic [ADDR_W-1:0]  w_next_pc;
  logic               w_accept;
  logic               w_capture;

  next_pc_calc u_next_pc_calc (
    .pc          (r_pc),
    .instruction (r_instruction),
    .BrTaken     (BrTaken),
    .UncondBr    (UncondBr),
    .next_pc     (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        imem_req  = 1'b1;
        w_capture = imem_valid;
        if (imem_valid)
          w_state_next = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        w_accept    = ~stall;
        if (!stall)
          w_state_next = REQ;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_pc          <= RESET_PC;
      r_instruction <= '0;
    end else begin
      if (w_capture) begin
        r_instruction <= imem_data;
        r_pc          <= r_fetch_pc;
      end
      if (w_accept)
        r_fetch_pc <= w_next_pc;
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign instruction = r_instruction;
  assign pc          = r_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_capture)
        r_fetch_count <= r_fetch_count + 32'd1;
      if (instr_valid && stall)
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// tb_instr_fetch : directed + randomized check of instr_fetch against a PC model
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        BrTaken = 1'b0;
  logic        UncondBr = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_fpc = 64'h0;
  int          exp_fetches = 0;
  int          exp_stalls = 0;

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .BrTaken     (BrTaken),
    .UncondBr    (UncondBr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .instruction (instruction),
    .pc          (pc),
    .instr_valid (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural target: signed word offset times four, wrapping mod 2^64
  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] w,
                                           input bit br, input bit ub);
    longint off;
    if (!br) return p + 64'd4;
    if (ub) begin
      off = longint'(w[25:0]);
      if (w[25]) off = off - (longint'(1) <<< 26);
    end else begin
      off = longint'(w[23:5]);
      if (w[23]) off = off - (longint'(1) <<< 19);
    end
    return p + 64'(off * 4);
  endfunction

  function automatic logic [31:0] b_word(input logic [63:0] target, input logic [63:0] from);
    logic [63:0] d;
    d = target - from;
    return {6'b000101, d[27:2]};
  endfunction

  task automatic do_fetch(input logic [31:0] word, input int lat, input int stalls,
                          input bit br, input bit ub, input bit junk);
    int i;
    i = 0;
    while (imem_req !== 1'b1 && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("req_seen", imem_req, 64'd1);
    chk("req_addr", imem_addr, exp_fpc);
    for (int l = 0; l < lat; l++) begin
      @(negedge clk);
      chk("req_wait", {imem_req, imem_addr[62:0]}, {1'b1, exp_fpc[62:0]});
    end
    imem_valid = 1'b1;
    imem_data  = word;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = $urandom;
    exp_fetches++;
    chk("hold_valid", instr_valid, 64'd1);
    chk("hold_instr", instruction, word);
    chk("hold_pc", pc, exp_fpc);
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      imem_valid = junk;
      BrTaken    = $urandom;
      UncondBr   = $urandom;
      @(negedge clk);
      exp_stalls++;
      chk("stall_valid", instr_valid, 64'd1);
      chk("stall_instr", instruction, word);
      chk("stall_pc", pc, exp_fpc);
      chk("stall_noreq", imem_req, 64'd0);
    end
    stall      = 1'b0;
    imem_valid = 1'b0;
    BrTaken    = br;
    UncondBr   = ub;
    @(negedge clk);
    exp_fpc  = ref_next(exp_fpc, word, br, ub);
    BrTaken  = $urandom;
    UncondBr = $urandom;
    chk("acc_drop", instr_valid, 64'd0);
    chk("acc_req", imem_req, 64'd1);
    chk("next_addr", imem_addr, exp_fpc);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 64'd0);
    chk("rst_valid", instr_valid, 64'd0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", instruction, 64'h0);
    chk("rst_addr", imem_addr, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fcnt", fetch_count, 64'd0);
    chk("rst_scnt", stall_count, 64'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("req_cycle1", imem_req, 64'd1);

    do_fetch(32'h91000421, 1, 0, 1'b0, 1'b0, 1'b0);
    do_fetch(b_word(64'h100, exp_fpc), 0, 0, 1'b1, 1'b1, 1'b0);
    do_fetch(32'h17FFFFFE, 0, 5, 1'b1, 1'b1, 1'b1);
    do_fetch(b_word(64'h40, exp_fpc), 2, 1, 1'b1, 1'b1, 1'b0);
    do_fetch(32'hB4000060, 0, 0, 1'b1, 1'b0, 1'b0);
    do_fetch(b_word(64'hFFFF_FFFF_FFFF_FFFC, exp_fpc), 0, 0, 1'b1, 1'b1, 1'b0);
    do_fetch($urandom, 1, 0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++)
      do_fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset while REQ is outstanding; memory answers one cycle late
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_req", imem_req, 64'd0);
    chk("midrst_valid", instr_valid, 64'd0);
    reset      = 1'b1;
    imem_valid = 1'b1;
    imem_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_valid  = 1'b0;
    exp_fpc     = 64'h0;
    exp_fetches = 0;
    exp_stalls  = 0;
    chk("late_valid", instr_valid, 64'd0);
    chk("late_instr", instruction, 64'h0);
    chk("restart_req", imem_req, 64'd1);
    chk("restart_addr", imem_addr, 64'h0);

    for (int k = 0; k < 4; k++)
      do_fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);

`ifdef FETCH_PERF_CNT_EN
    chk("fetch_count", fetch_count, 64'(exp_fetches));
    chk("stall_count", stall_count, 64'(exp_stalls));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
